// File: rtl/plic_seq_pkg.sv
// Shared state encoding and default PLIC address map for plic_claim_sequencer.
// Optional watchdog selected with PLIC_SEQ_TIMEOUT_EN (see top).
package plic_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLAIM    = 3'd1,
    DELIVER  = 3'd2,
    SERVICE  = 3'd3,
    COMPLETE = 3'd4
  } seq_state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h0C00_0000;
  localparam logic [31:0] DEFAULT_CC_OFFSET  = 32'h0020_0004;
  localparam logic [31:0] DEFAULT_CTX_STRIDE = 32'h0000_1000;

  // Claim/complete register of a context; 32-bit arithmetic wraps silently.
  function automatic logic [31:0] cc_addr(input logic [31:0] tgt,
                                          input logic [31:0] base   = DEFAULT_BASE_ADDR,
                                          input logic [31:0] cc_off = DEFAULT_CC_OFFSET,
                                          input logic [31:0] stride = DEFAULT_CTX_STRIDE);
    return base + cc_off + tgt * stride;
  endfunction

endpackage

// File: rtl/reg_intf_pkg.sv
// Register-interface bus types shared by every PLIC-side bus master in this slice.
package reg_intf_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_intf_req_a32_d32;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_intf_resp_d32;

endpackage

// File: rtl/plic_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer past the winner when advance is strobed.
module plic_rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_q;
  logic          gnt_any;

  // Smallest circular distance from the pointer wins.
  always_comb begin
    int d;
    int best;
    best    = N;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      d = (i + N - int'(ptr_q)) % N;
      if (req[i] && (d < best)) begin
        best    = d;
        gnt_idx = IW'(i);
      end
    end
    gnt_any = (best < N);
    for (int i = 0; i < N; i++) begin
      gnt_onehot[i] = gnt_any && (IW'(i) == gnt_idx);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (advance && gnt_any) begin
      ptr_q <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/plic_claim_sequencer.sv
// Hardware PLIC claim/complete engine for non-hart targets.
// Define PLIC_SEQ_TIMEOUT_EN to add the SERVICE watchdog and the timeout_o port.
module plic_claim_sequencer
  import plic_seq_pkg::*;
  import reg_intf_pkg::*;
#(
  parameter int unsigned N_TARGET   = 2,
  parameter int unsigned N_SOURCE   = 30,
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter logic [31:0] CC_OFFSET  = DEFAULT_CC_OFFSET,
  parameter logic [31:0] CTX_STRIDE = DEFAULT_CTX_STRIDE
`ifdef PLIC_SEQ_TIMEOUT_EN
  ,parameter int unsigned TIMEOUT   = 1024
`endif
  ,localparam int SRCW = $clog2(N_SOURCE + 1)
  ,localparam int TW   = (N_TARGET > 1) ? $clog2(N_TARGET) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_TARGET-1:0] eip_i,
  output reg_intf_req_a32_d32 req_o,
  input  reg_intf_resp_d32    resp_i,
  output logic                irq_valid_o,
  input  logic                irq_ready_i,
  output logic [SRCW-1:0]     irq_id_o,
  output logic [TW-1:0]       irq_tgt_o,
  input  logic                done_i,
  output logic                busy_o,
  output logic                spurious_o,
  output logic                bus_err_o
`ifdef PLIC_SEQ_TIMEOUT_EN
  ,output logic               timeout_o
`endif
);

  seq_state_e state_q, state_d;

  logic [N_TARGET-1:0] gnt_onehot;
  logic [TW-1:0]       gnt_idx;
  logic                grant;
  logic [TW-1:0]       tgt_q;
  logic [SRCW-1:0]     id_q;
  logic                spurious_q, bus_err_q;

  logic [SRCW-1:0] rsp_id;
  logic            claim_done, claim_spur, claim_range, claim_err, claim_ok, cmpl_err;
  logic            timeout_hit;

  plic_rr_arbiter #(.N(N_TARGET)) u_arb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req        (eip_i),
    .advance    (state_q == IDLE),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx)
  );

  assign grant = (state_q == IDLE) && (|gnt_onehot);

  // Claim response classification; ID 0 is spurious before the range check.
  assign rsp_id      = resp_i.rdata[SRCW-1:0];
  assign claim_done  = (state_q == CLAIM) && resp_i.ready;
  assign claim_spur  = claim_done && !resp_i.error && (rsp_id == '0);
  assign claim_range = claim_done && !resp_i.error && (rsp_id != '0) &&
                       (resp_i.rdata > 32'(N_SOURCE));
  assign claim_err   = claim_done && (resp_i.error || claim_range);
  assign claim_ok    = claim_done && !resp_i.error && !claim_spur && !claim_range;
  assign cmpl_err    = (state_q == COMPLETE) && resp_i.ready && resp_i.error;

`ifdef PLIC_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] svc_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      svc_cnt_q <= '0;
    end else if (state_q != SERVICE) begin
      svc_cnt_q <= '0;
    end else begin
      svc_cnt_q <= svc_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == SERVICE) && !done_i && (svc_cnt_q == CW'(TIMEOUT - 1));
  assign timeout_o   = timeout_hit;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (grant) state_d = CLAIM;
      CLAIM:    if (resp_i.ready) state_d = claim_ok ? DELIVER : IDLE;
      DELIVER:  if (irq_ready_i) state_d = SERVICE;
      SERVICE:  if (done_i || timeout_hit) state_d = COMPLETE;
      COMPLETE: if (resp_i.ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tgt_q      <= '0;
      id_q       <= '0;
      spurious_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      if (grant)    tgt_q <= gnt_idx;
      if (claim_ok) id_q  <= rsp_id;
      spurious_q <= claim_spur;
      bus_err_q  <= claim_err || cmpl_err;
    end
  end

  // Bus request is decoded from registered state only, never from resp_i.
  always_comb begin
    req_o = '0;
    case (state_q)
      CLAIM: begin
        req_o.valid = 1'b1;
        req_o.addr  = cc_addr(32'(tgt_q), BASE_ADDR, CC_OFFSET, CTX_STRIDE);
      end
      COMPLETE: begin
        req_o.valid = 1'b1;
        req_o.write = 1'b1;
        req_o.addr  = cc_addr(32'(tgt_q), BASE_ADDR, CC_OFFSET, CTX_STRIDE);
        req_o.wdata = 32'(id_q);
        req_o.wstrb = 4'hF;
      end
      default: req_o = '0;
    endcase
  end

  assign irq_valid_o = (state_q == DELIVER);
  assign irq_id_o    = id_q;
  assign irq_tgt_o   = tgt_q;
  assign busy_o      = (state_q != IDLE);
  assign spurious_o  = spurious_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_plic_claim_sequencer.sv
// Randomized bench for plic_claim_sequencer against a transaction-level model
// of round-robin selection and claim outcome rules.
module tb_plic_claim_sequencer;
  import reg_intf_pkg::*;

  localparam int          N_TARGET = 2;
  localparam int          N_SOURCE = 30;
  localparam logic [31:0] BASE     = 32'h0C00_0000;
  localparam logic [31:0] CCO      = 32'h0020_0004;
  localparam logic [31:0] STR      = 32'h0000_1000;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [1:0]          eip_i;
  reg_intf_req_a32_d32 req_o;
  reg_intf_resp_d32    resp_i;
  logic                irq_valid_o, irq_ready_i;
  logic [4:0]          irq_id_o;
  logic                irq_tgt_o;
  logic                done_i, busy_o, spurious_o, bus_err_o;
`ifdef PLIC_SEQ_TIMEOUT_EN
  logic                timeout_o;
`endif

  int checks = 0;
  int passed = 0;
  int model_ptr = 0;

  always #5 clk_i = ~clk_i;

  plic_claim_sequencer #(
    .N_TARGET(N_TARGET), .N_SOURCE(N_SOURCE),
    .BASE_ADDR(BASE), .CC_OFFSET(CCO), .CTX_STRIDE(STR)
`ifdef PLIC_SEQ_TIMEOUT_EN
    ,.TIMEOUT(16)
`endif
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .eip_i       (eip_i),
    .req_o       (req_o),
    .resp_i      (resp_i),
    .irq_valid_o (irq_valid_o),
    .irq_ready_i (irq_ready_i),
    .irq_id_o    (irq_id_o),
    .irq_tgt_o   (irq_tgt_o),
    .done_i      (done_i),
    .busy_o      (busy_o),
    .spurious_o  (spurious_o),
    .bus_err_o   (bus_err_o)
`ifdef PLIC_SEQ_TIMEOUT_EN
    ,.timeout_o  (timeout_o)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Next context in circular order from the model pointer that has a pending line.
  function automatic int model_pick(input logic [1:0] eip);
    for (int k = 0; k < N_TARGET; k++) begin
      int t;
      t = (model_ptr + k) % N_TARGET;
      if (((eip >> t) & 2'b01) != 2'b00) return t;
    end
    return 0;
  endfunction

  // 0 = deliver, 1 = spurious, 2 = bus error
  function automatic int model_outcome(input logic err, input logic [31:0] rdata);
    if (err) return 2;
    if ((rdata & 32'd31) == 32'd0) return 1;
    if (rdata > 32'(N_SOURCE)) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] model_addr(input int tgt);
    return BASE + CCO + 32'(tgt) * STR;
  endfunction

  task automatic applyStimulus(input logic [1:0] eip, input bit keep, input logic [31:0] rdata,
                               input bit err_claim, input int claim_wait, input int dlv_wait,
                               input bit done_early, input int svc_wait, input int cmp_wait,
                               input bit err_cmp);
    int tgt, outc, lat;
    logic [31:0] exp_addr, exp_id;
    tgt       = model_pick(eip);
    model_ptr = (tgt + 1) % N_TARGET;
    exp_addr  = model_addr(tgt);
    outc      = model_outcome(err_claim, rdata);
    exp_id    = rdata & 32'd31;

    eip_i = eip;
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!req_o.valid && lat < 8);
    checkOutput("claim_latency", 32'(lat), 32'd1);
    checkOutput("claim_addr", req_o.addr, exp_addr);
    checkOutput("claim_write", 32'(req_o.write), 32'd0);
    checkOutput("claim_wstrb", 32'(req_o.wstrb), 32'd0);
    checkOutput("claim_busy", 32'(busy_o), 32'd1);
    if (!keep) eip_i = '0;

    repeat (claim_wait) begin
      @(negedge clk_i);
      checkOutput("claim_hold_valid", 32'(req_o.valid), 32'd1);
      checkOutput("claim_hold_addr", req_o.addr, exp_addr);
    end
    resp_i.rdata = rdata; resp_i.error = err_claim; resp_i.ready = 1'b1;
    @(negedge clk_i);
    resp_i = '0;
    checkOutput("spurious_pulse", 32'(spurious_o), 32'(outc == 1));
    checkOutput("bus_err_pulse", 32'(bus_err_o), 32'(outc == 2));
    checkOutput("irq_valid", 32'(irq_valid_o), 32'(outc == 0));
    if (outc != 0) begin
      checkOutput("abort_busy", 32'(busy_o), 32'd0);
      if (!keep) begin
        @(negedge clk_i);
        checkOutput("abort_pulse_width", 32'({spurious_o, bus_err_o}), 32'd0);
        checkOutput("abort_no_req", 32'(req_o.valid), 32'd0);
      end
      return;
    end
    checkOutput("irq_id", 32'(irq_id_o), exp_id);
    checkOutput("irq_tgt", 32'(irq_tgt_o), 32'(tgt));

    for (int i = 0; i < dlv_wait; i++) begin
      if (i == 1) done_i = 1'b1;
      @(negedge clk_i);
      done_i = 1'b0;
      checkOutput("deliver_hold_valid", 32'(irq_valid_o), 32'd1);
      checkOutput("deliver_hold_id", 32'(irq_id_o), exp_id);
    end
    irq_ready_i = 1'b1; done_i = done_early;
    @(negedge clk_i);
    irq_ready_i = 1'b0; done_i = 1'b0;
    checkOutput("service_valid_low", 32'(irq_valid_o), 32'd0);
    checkOutput("service_no_req", 32'(req_o.valid), 32'd0);
    repeat (svc_wait) begin
      @(negedge clk_i);
      checkOutput("service_wait_no_req", 32'(req_o.valid), 32'd0);
    end

    done_i = 1'b1;
    @(negedge clk_i);
    done_i = 1'b0;
    checkOutput("cmpl_valid", 32'(req_o.valid), 32'd1);
    checkOutput("cmpl_write", 32'(req_o.write), 32'd1);
    checkOutput("cmpl_addr", req_o.addr, exp_addr);
    checkOutput("cmpl_wdata", req_o.wdata, exp_id);
    checkOutput("cmpl_wstrb", 32'(req_o.wstrb), 32'hF);
    repeat (cmp_wait) begin
      @(negedge clk_i);
      checkOutput("cmpl_hold_valid", 32'(req_o.valid), 32'd1);
    end
    resp_i.error = err_cmp; resp_i.ready = 1'b1;
    @(negedge clk_i);
    resp_i = '0;
    checkOutput("end_busy", 32'(busy_o), 32'd0);
    checkOutput("end_no_req", 32'(req_o.valid), 32'd0);
    checkOutput("cmpl_bus_err", 32'(bus_err_o), 32'(err_cmp));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_ni = 1'b0; eip_i = '0; resp_i = '0; irq_ready_i = 1'b0; done_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_req", 32'(req_o), 32'd0);
    checkOutput("reset_irq_valid", 32'(irq_valid_o), 32'd0);
    checkOutput("reset_id_tgt", 32'({irq_id_o, irq_tgt_o}), 32'd0);
    checkOutput("reset_pulses", 32'({spurious_o, bus_err_o}), 32'd0);
    rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("idle_no_bus", 32'(req_o.valid), 32'd0);
    end

    $display("[TB] basic claim/complete");
    applyStimulus(2'b01, 1'b0, 32'd5, 1'b0, 0, 0, 1'b0, 2, 0, 1'b0);

    $display("[TB] reset during claim");
    eip_i = 2'b10;
    @(negedge clk_i);
    eip_i = '0;
    rst_ni = 1'b0;
    #1;
    checkOutput("midreset_busy", 32'(busy_o), 32'd0);
    checkOutput("midreset_req", 32'(req_o.valid), 32'd0);
    checkOutput("midreset_tgt", 32'(irq_tgt_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_ptr = 0;

    $display("[TB] round robin with both lines held");
    for (int r = 0; r < 4; r++) applyStimulus(2'b11, 1'b1, 32'(r + 10), 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    eip_i = '0;

    $display("[TB] directed corner cases");
    applyStimulus(2'b10, 1'b0, 32'd0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    applyStimulus(2'b01, 1'b0, 32'd7, 1'b0, 20, 0, 1'b0, 0, 0, 1'b0);
    applyStimulus(2'b01, 1'b0, 32'd30, 1'b0, 0, 10, 1'b1, 3, 2, 1'b0);
    applyStimulus(2'b11, 1'b0, 32'd31, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    applyStimulus(2'b11, 1'b0, 32'd3, 1'b1, 1, 0, 1'b0, 0, 0, 1'b0);
    applyStimulus(2'b10, 1'b0, 32'd1, 1'b0, 0, 0, 1'b0, 0, 3, 1'b1);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      logic [31:0] rd;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      rd = 32'd0;
      else if (sel == 1) rd = 32'(31 + $urandom_range(0, 33));
      else if (sel == 2) rd = $urandom | 32'h100;
      else               rd = 32'($urandom_range(1, N_SOURCE));
      applyStimulus(2'($urandom_range(1, 3)), 1'b0, rd, ($urandom_range(0, 9) == 0),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    bit'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
    end

`ifdef PLIC_SEQ_TIMEOUT_EN
    begin
      int tgt, k;
      $display("[TB] service watchdog");
      tgt = model_pick(2'b01);
      model_ptr = (tgt + 1) % N_TARGET;
      eip_i = 2'b01;
      @(negedge clk_i);
      eip_i = '0;
      resp_i.rdata = 32'd3; resp_i.ready = 1'b1;
      @(negedge clk_i);
      resp_i = '0;
      irq_ready_i = 1'b1;
      @(negedge clk_i);
      irq_ready_i = 1'b0;
      k = 1;
      while (!timeout_o && k < 40) begin
        @(negedge clk_i);
        k++;
      end
      checkOutput("timeout_cycle", 32'(k), 32'd16);
      @(negedge clk_i);
      checkOutput("timeout_pulse_width", 32'(timeout_o), 32'd0);
      checkOutput("timeout_cmpl_write", 32'({req_o.valid, req_o.write}), 32'd3);
      checkOutput("timeout_cmpl_addr", req_o.addr, model_addr(tgt));
      resp_i.ready = 1'b1;
      @(negedge clk_i);
      resp_i = '0;
      checkOutput("timeout_end_busy", 32'(busy_o), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
